regfile_dumper: RTL and testbench

//   Read-side initiator for the 2R1W regfile: walks every architectural register through

---
 rtl/regdump_pkg.sv | 21 ++
 rtl/regfile_dumper.sv | 80 ++++++++
 tb/tb_regfile_dumper.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/regdump_pkg.sv
// Shared constants and state encoding for the regfile dumper.
// Defining REGDUMP_SKIP_X0_EN makes the walk start at x1 instead of x0.
package regdump_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t READ = 2'd1;
    localparam state_t SEND = 2'd2;
    localparam state_t DONE = 2'd3;

    localparam int NREGS_DEFAULT = 32;
    localparam int LAST_IDX      = NREGS_DEFAULT - 1;

`ifdef REGDUMP_SKIP_X0_EN
    localparam int FIRST_IDX = 1;
`else
    localparam int FIRST_IDX = 0;
`endif

endpackage

// File: rtl/regfile_dumper.sv
// Walks the regfile through read port 1 and streams {index, value} beats on a valid/ready port.
// REGDUMP_SKIP_X0_EN (see regdump_pkg) skips the hardwired-zero x0.
module regfile_dumper
    import regdump_pkg::*;
#(
    parameter int NREGS = NREGS_DEFAULT,
    parameter int AW    = $clog2(NREGS),
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] ra,
    input  logic [DW-1:0] rd,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [AW-1:0] m_idx,
    output logic [DW-1:0] m_data,
    output logic          m_last
);

    localparam logic [AW-1:0] FIRST = AW'(FIRST_IDX);
    localparam logic [AW-1:0] LAST  = AW'(NREGS - 1);

    state_t        state;
    logic [AW-1:0] idx;

    // The walk ends on the last beat's handshake, so idx never increments past LAST.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            m_valid <= 1'b0;
            m_idx   <= '0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx   <= FIRST;
                        state <= READ;
                    end
                end
                READ: begin
                    m_data  <= rd;
                    m_idx   <= idx;
                    m_last  <= (idx == LAST);
                    m_valid <= 1'b1;
                    state   <= SEND;
                end
                SEND: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        if (m_last) begin
                            m_last <= 1'b0;
                            state  <= DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= READ;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ra   = idx;
    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_regfile_dumper.sv
// Directed bench for regfile_dumper with a behavioural 2R1W regfile (x0 hardwired to zero).
// Build with REGDUMP_SKIP_X0_EN defined to exercise the x1-first walk.
module tb_regfile_dumper;
    import regdump_pkg::*;

    localparam int NR = 32;
    localparam int FIRST = FIRST_IDX;

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [4:0]  ra;
    logic [31:0] rd;
    logic        m_valid;
    logic        m_ready;
    logic [4:0]  m_idx;
    logic [31:0] m_data;
    logic        m_last;

    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [31:0] regs [NR];
    logic [31:0] expVal [NR];

    int vectors = 0;
    int miscompares = 0;

    regfile_dumper #(.NREGS(NR), .AW(5), .DW(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .ra      (ra),
        .rd      (rd),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_idx   (m_idx),
        .m_data  (m_data),
        .m_last  (m_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (we3 && a3 != 5'd0) regs[a3] <= wd3;
    end
    assign rd = (ra == 5'd0) ? 32'h0 : regs[ra];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic writeReg(input int a, input logic [31:0] d);
        we3 = 1'b1;
        a3  = 5'(a);
        wd3 = d;
        tick();
        we3 = 1'b0;
        if (a != 0) expVal[a] = d;
    endtask

    // One dump: optional stall on a beat, start pokes while busy / in DONE, or reset abort.
    task automatic applyStimulus(input string name, input int stallIdx, input int stallCycles,
                                 input int pokeIdx, input bit pokeAtDone, input int abortIdx);
        int c;
        int expIdx;
        int stallCnt;
        int dones;
        int lastC;
        int doneC;
        bit finished;
        logic [31:0] heldData;
        logic [4:0]  heldIdx;
        expIdx = FIRST;
        stallCnt = 0;
        dones = 0;
        lastC = -1;
        doneC = -1;
        finished = 1'b0;
        heldData = '0;
        heldIdx = '0;
        m_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput({name, " busy_after_start"}, 32'(busy), 32'd1);
        checkOutput({name, " ra_first"}, 32'(ra), 32'(FIRST));
        c = 0;
        while (!finished && c < 400) begin
            tick();
            c++;
            start = 1'b0;
            m_ready = 1'b1;
            if (done) begin
                dones++;
                doneC = c;
                checkOutput({name, " done_after_last"}, 32'(c), 32'(lastC + 1));
                if (pokeAtDone) start = 1'b1;
            end else if (doneC >= 0) begin
                finished = 1'b1;
                checkOutput({name, " busy_drop"}, 32'(busy), 32'd0);
            end else if (m_valid) begin
                if (abortIdx >= 0 && int'(m_idx) == abortIdx) begin
                    rst = 1'b1;
                    #1;
                    checkOutput({name, " abort_valid"}, 32'(m_valid), 32'd0);
                    checkOutput({name, " abort_busy"}, 32'(busy), 32'd0);
                    checkOutput({name, " abort_idx"}, 32'(m_idx), 32'd0);
                    checkOutput({name, " abort_data"}, m_data, 32'd0);
                    checkOutput({name, " abort_ra"}, 32'(ra), 32'd0);
                    checkOutput({name, " abort_last"}, 32'(m_last), 32'd0);
                    tick();
                    rst = 1'b0;
                    for (int k = 0; k < 4; k++) begin
                        tick();
                        checkOutput({name, " no_done_after_abort"}, 32'(done), 32'd0);
                    end
                    checkOutput({name, " idle_after_abort"}, 32'(busy), 32'd0);
                    return;
                end
                if (pokeIdx >= 0 && int'(m_idx) == pokeIdx) start = 1'b1;
                if (int'(m_idx) == stallIdx && stallCnt < stallCycles) begin
                    if (stallCnt > 0) begin
                        checkOutput({name, " stall_idx"}, 32'(m_idx), 32'(heldIdx));
                        checkOutput({name, " stall_data"}, m_data, heldData);
                    end
                    heldIdx = m_idx;
                    heldData = m_data;
                    stallCnt++;
                    m_ready = 1'b0;
                end else begin
                    checkOutput({name, " beat_idx"}, 32'(m_idx), 32'(expIdx));
                    checkOutput({name, " beat_data"}, m_data, expVal[expIdx]);
                    checkOutput({name, " beat_last"}, 32'(m_last), 32'(expIdx == LAST_IDX));
                    if (m_last) lastC = c;
                    expIdx++;
                end
            end else if (busy) begin
                checkOutput({name, " ra_read"}, 32'(ra), 32'(expIdx));
            end
        end
        checkOutput({name, " beat_count"}, 32'(expIdx - FIRST), 32'(NR - FIRST));
        checkOutput({name, " done_count"}, 32'(dones), 32'd1);
        checkOutput({name, " last_handshake_cycle"}, 32'(lastC), 32'(2 * (NR - FIRST) - 1 + stallCycles));
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        m_ready = 1'b0;
        we3 = 1'b0;
        a3 = '0;
        wd3 = '0;
        expVal[0] = 32'h0;
        tick();
        tick();
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset valid", 32'(m_valid), 32'd0);
        checkOutput("reset ra", 32'(ra), 32'd0);
        checkOutput("reset idx", 32'(m_idx), 32'd0);
        checkOutput("reset data", m_data, 32'd0);
        checkOutput("reset last", 32'(m_last), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 1; i < NR; i++) writeReg(i, 32'hA5000000 ^ (32'(i) * 32'h01010101));
        writeReg(1, 32'hffff5555);
        writeReg(31, 32'h12345678);
        $display("[TB] basic dump");
        applyStimulus("dump1", -1, 0, -1, 1'b0, -1);

        writeReg(0, 32'hffffaaaa);
        writeReg(5, 32'hdeadbeef);
        $display("[TB] x0 write ignored");
        applyStimulus("x0", -1, 0, -1, 1'b0, -1);

        $display("[TB] backpressure on beat 3");
        applyStimulus("stall", 3, 5, -1, 1'b0, -1);

        $display("[TB] start while busy and in DONE");
        applyStimulus("poke", -1, 0, 10, 1'b1, -1);

        $display("[TB] reset mid-dump");
        applyStimulus("abort", -1, 0, -1, 1'b0, 7);
        applyStimulus("after_abort", -1, 0, -1, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
